// File: rtl/dmem_pkg.sv
// Shared constants, lane helper and pipeline-stage bundle for the data memory.
package dmem_pkg;

  localparam int DATA_W_32 = 32;
  localparam int DATA_W_64 = 64;
  localparam int MAX_DATA_W = DATA_W_64;

  function automatic int lanes(input int width);
    return width / 8;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic                  isStore;
    logic [MAX_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-enabled write port, registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 16384
) (
  input  logic                           clock,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [lanes(DATA_W)-1:0]       be,
  output logic [DATA_W-1:0]              rdata
);

  localparam int LANES = lanes(DATA_W);

  // Contents survive reset; only power-up state is zero.
  logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_pipelined.sv
// Pipelined data memory: handshake, error decode, read pipeline, counters.
// Define DMEM_PERF_COUNTERS_EN to build the performance counters.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int READ_LAT    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic                     reqWrite,
  input  logic [31:0]              reqAddr,
  input  logic [DATA_W-1:0]        reqWdata,
  input  logic [lanes(DATA_W)-1:0] reqByteEn,
  output logic                     respValid,
  input  logic                     respReady,
  output logic [DATA_W-1:0]        respRdata,
  output logic                     respErr,
  output logic                     respIsStore,
  output logic [31:0]              cntLoads,
  output logic [31:0]              cntStores,
  output logic [31:0]              cntErrors,
  output logic [31:0]              cntStalls
);

  localparam int BW = $clog2(lanes(DATA_W));
  localparam int IW = $clog2(DEPTH_WORDS);

  logic              stall;
  logic              accept;
  logic              err;
  logic              load_ok;
  logic              store_ok;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] arr_rdata;
  stage_t            pipe [READ_LAT];
  stage_t            s0;
  stage_t            last;
  logic              unused_hi;

  assign stall    = respValid & ~respReady;
  assign reqReady = reset & ~stall;
  assign accept   = reqValid & reqReady;

  assign idx      = reqAddr[BW+IW-1:BW];
  assign err      = (|(reqAddr >> (BW + IW))) | (|reqAddr[BW-1:0]);
  assign load_ok  = accept & ~err & ~reqWrite;
  assign store_ok = accept & ~err & reqWrite;

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock (clock),
    .wr_en (store_ok),
    .rd_en (load_ok),
    .idx   (idx),
    .wdata (reqWdata),
    .be    (reqByteEn),
    .rdata (arr_rdata)
  );

  // Stage 0 borrows its data from the array's read register.
  always_comb begin
    s0      = pipe[0];
    s0.data = '0;
    if (pipe[0].valid && !pipe[0].err && !pipe[0].isStore) begin
      s0.data[DATA_W-1:0] = arr_rdata;
    end
  end

  always_comb begin
    last = (READ_LAT == 1) ? s0 : pipe[READ_LAT-1];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0].valid   <= accept;
      pipe[0].err     <= accept & err;
      pipe[0].isStore <= accept & reqWrite;
      pipe[0].data    <= '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe[i] <= (i == 1) ? s0 : pipe[i-1];
      end
    end
  end

  assign respValid   = last.valid;
  assign respErr     = last.err;
  assign respIsStore = last.isStore;
  assign respRdata   = last.data[DATA_W-1:0];
  assign unused_hi   = ^last.data;

`ifdef DMEM_PERF_COUNTERS_EN
  logic [31:0] loads_q;
  logic [31:0] stores_q;
  logic [31:0] errors_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
      stalls_q <= '0;
    end else begin
      if (load_ok)         loads_q  <= loads_q + 32'd1;
      if (store_ok)        stores_q <= stores_q + 32'd1;
      if (accept && err)   errors_q <= errors_q + 32'd1;
      if (stall)           stalls_q <= stalls_q + 32'd1;
    end
  end

  assign cntLoads  = loads_q;
  assign cntStores = stores_q;
  assign cntErrors = errors_q;
  assign cntStalls = stalls_q;
`else
  assign cntLoads  = '0;
  assign cntStores = '0;
  assign cntErrors = '0;
  assign cntStalls = '0;
`endif

endmodule
